// File: rtl/comparator_serial_nbit_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state encodings
// and one-hot result constants ordered {equal, greater, lesser}.
package comparator_serial_nbit_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_EQ   = 3'b100;
   localparam logic [2:0] RES_GT   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;

   // Exchange greater and lesser, keep equal; used when a sign bit flips the sense.
   function automatic logic [2:0] swap_sense(input logic [2:0] res);
      return {res[2], res[0], res[1]};
   endfunction

endpackage

// File: rtl/comparator_serial_nbit_1bit.sv
// Single-bit magnitude cell of the comparator library: one-hot equal/greater/lesser of a versus b.
module comparator_1bit (
   input  logic a,
   input  logic b,
   output logic equal,
   output logic greater,
   output logic lesser
);

   assign equal   = ~(a ^ b);
   assign greater = a & ~b;
   assign lesser  = ~a & b;

endmodule

// File: rtl/comparator_serial_nbit.sv
// N-bit MSB-first bit-serial magnitude comparator with start/done handshake and registered one-hot flags.
// Define COMPARATOR_SIGNED_EN for a two's-complement compare; otherwise the compare is unsigned.
module comparator_serial_nbit
   import comparator_serial_nbit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic             greater,
   output logic             lesser
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

   state_t           state_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [2:0]       flags_r;
   logic             busy_r;
   logic             done_r;

   logic             bit_eq_s;
   logic             bit_gt_s;
   logic             bit_lt_s;
   logic [2:0]       bit_res_s;

   comparator_1bit u_cell (
      .a       (a_r[idx_r]),
      .b       (b_r[idx_r]),
      .equal   (bit_eq_s),
      .greater (bit_gt_s),
      .lesser  (bit_lt_s)
   );

   // Result of the bit under examination, with the sign-bit fix-up in the signed build.
   always_comb begin
      bit_res_s = {bit_eq_s, bit_gt_s, bit_lt_s};
`ifdef COMPARATOR_SIGNED_EN
      if ((idx_r == MSB_IDX) && !bit_eq_s) begin
         bit_res_s = swap_sense({bit_eq_s, bit_gt_s, bit_lt_s});
      end else begin
         bit_res_s = {bit_eq_s, bit_gt_s, bit_lt_s};
      end
`endif
   end

   // Control FSM, bit-index counter, operand capture and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         idx_r   <= IDX_W'(0);
         a_r     <= WIDTH'(0);
         b_r     <= WIDTH'(0);
         flags_r <= RES_NONE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  idx_r   <= MSB_IDX;
                  flags_r <= RES_NONE;
                  busy_r  <= 1'b1;
                  state_r <= S_COMPARE;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_COMPARE: begin
               if (!bit_eq_s) begin
                  flags_r <= bit_res_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else if (idx_r == IDX_W'(0)) begin
                  flags_r <= RES_EQ;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  idx_r   <= idx_r - IDX_W'(1);
               end
            end
            S_DONE: begin
               done_r <= 1'b0;
               // A start seen during the done cycle is accepted immediately.
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  idx_r   <= MSB_IDX;
                  flags_r <= RES_NONE;
                  busy_r  <= 1'b1;
                  state_r <= S_COMPARE;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
               flags_r <= RES_NONE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign equal   = flags_r[2];
   assign greater = flags_r[1];
   assign lesser  = flags_r[0];

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Scoreboard bench for comparator_serial_nbit (WIDTH=8); expected flags and latency are queued by the driver.
module tb_comparator_serial_nbit;

   localparam logic [2:0] EQ = 3'b100;
   localparam logic [2:0] GT = 3'b010;
   localparam logic [2:0] LT = 3'b001;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic       equal;
   logic       greater;
   logic       lesser;

   comparator_serial_nbit #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .equal   (equal),
      .greater (greater),
      .lesser  (lesser)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] flags;
      int         lat;
      int         start_cyc;
      string      name;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   logic       rst_q;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         mon_en = 1'b0;
   bit         have_res = 1'b0;
   logic [2:0] last_flags = 3'b000;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on done and checks flag invariants every cycle.
   always @(negedge clk) begin
      logic [2:0] fl;
      exp_t       e;
      fl = {equal, greater, lesser};
      if (rst_q === 1'b1) begin
         check("reset_busy", {31'd0, busy}, 32'd0);
         check("reset_done", {31'd0, done}, 32'd0);
         check("reset_flags", {29'd0, fl}, 32'd0);
         have_res = 1'b0;
      end else if (mon_en) begin
         n_cmp++;
         if (!(fl == 3'b000 || fl == EQ || fl == GT || fl == LT)) begin
            n_bad++;
            $display("FAIL onehot: got %b, expected one-hot or zero", fl);
         end
         n_cmp++;
         if (done && busy) begin
            n_bad++;
            $display("FAIL done_busy: got done=1 busy=1, expected not both");
         end
         if (done) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check({e.name, "_flags"}, {29'd0, fl}, {29'd0, e.flags});
               check({e.name, "_latency"}, cyc - e.start_cyc + 1, e.lat);
            end
            have_res   = 1'b1;
            last_flags = fl;
         end else if (busy) begin
            check("flags_clear_busy", {29'd0, fl}, 32'd0);
         end else if (have_res) begin
            check("flags_hold", {29'd0, fl}, {29'd0, last_flags});
         end else begin
            check("flags_zero_idle", {29'd0, fl}, 32'd0);
         end
         if (sb.size() > 0 && (cyc - sb[0].start_cyc) > sb[0].lat + 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done, expected done after %0d cycles", sb[0].name, sb[0].lat);
            void'(sb.pop_front());
         end
      end
   end

   task automatic wait_done();
      for (int i = 0; i < 30; i++) begin
         if (done) break;
         @(negedge clk);
      end
   endtask

   task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] ef,
                        input int lat, input string nm);
      @(negedge clk);
      a     = va;
      b     = vb;
      start = 1'b1;
      sb.push_back('{ef, lat, cyc + 1, nm});
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
   endtask

   task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] ef,
                         input int lat, input string nm);
      issue(va, vb, ef, lat, nm);
      wait_done();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Equal operands with an ignored start pulse mid-compare.
      issue(8'hA5, 8'hA5, EQ, 9, "eq_a5");
      repeat (2) @(negedge clk);
      a     = 8'hFF;
      b     = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);

`ifdef COMPARATOR_SIGNED_EN
      run_op(8'h80, 8'h7F, LT, 2, "msb_80_7f");
      run_op(8'h7F, 8'hFF, GT, 2, "msb_7f_ff");
`else
      run_op(8'h80, 8'h7F, GT, 2, "msb_80_7f");
      run_op(8'h7F, 8'hFF, LT, 2, "msb_7f_ff");
`endif
      run_op(8'h12, 8'h13, LT, 9, "lsb_12_13");
      run_op(8'hF0, 8'hE0, GT, 5, "bit4_f0_e0");
      run_op(8'h00, 8'h00, EQ, 9, "eq_zero");

      // Reset in the middle of a compare: aborted, no done.
      @(negedge clk);
      a     = 8'h12;
      b     = 8'h13;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      run_op(8'h12, 8'h13, LT, 9, "after_reset");

      // Back-to-back: start held high through the done cycle.
      @(negedge clk);
      a     = 8'h01;
      b     = 8'h00;
      start = 1'b1;
      sb.push_back('{GT, 9, cyc + 1, "b2b_first"});
      @(negedge clk);
      wait_done();
      a     = 8'h00;
      b     = 8'h01;
      sb.push_back('{LT, 9, cyc + 1, "b2b_second"});
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected bench end");
      $fatal(1);
   end

endmodule
